ifu_prefetch: RTL and testbench

//  Next-generation fetch unit. Issues up to MAX_OUTSTANDING in-order AXI-lite read requests for

---
 rtl/ifu_prefetch.sv | 201 ++++++++++++++++++++
 tb/tb_ifu_prefetch.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction prefetcher.
//   Issues in-order AXI-lite reads for consecutive PCs and buffers the returned
//   words in a small fetch queue that feeds decode. A redirect flushes the queue
//   and restarts fetch at a new PC. Reads already in flight at the redirect are
//   drained and discarded when their responses arrive.
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   redirect_valid_i/_pc_i        flush and restart fetch at redirect_pc_i
//   araddr_o/arvalid_o/arready_i  AXI-lite read address channel
//   rdata_i/rresp_i/rvalid_i      AXI-lite read data channel (rresp != 0 is a fault)
//   rready_o                      always ready outside reset
//   inst_valid_o/inst_ready_i     fetch-queue head handshake towards decode
//   inst_pc_o/inst_snpc_o         head PC and head PC + 4
//   inst_o/inst_fault_o           head instruction word and access-fault flag
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC        = 32'h2000_0000,
    parameter int          FQ_DEPTH        = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_snpc_o,
    output logic [31:0] inst_o,
    output logic        inst_fault_o
);

    localparam int CW_OUT = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW_Q   = $clog2(FQ_DEPTH + 1);
    localparam int PW     = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam logic [31:0] MAX_OUT_C  = MAX_OUTSTANDING;
    localparam logic [31:0] FQ_DEPTH_C = FQ_DEPTH;

    // Fetch state
    logic [31:0]     fetch_pc_r, fetch_pc_n_s;
    logic [31:0]     rsp_pc_r, rsp_pc_n_s;
    logic [31:0]     araddr_r, araddr_n_s;
    logic            arvalid_r, arvalid_n_s;
    // Set while the pending AR was issued before a redirect: its response must be dropped.
    logic            ar_stale_r, ar_stale_n_s;
    logic            halted_r, halted_n_s;
    logic [CW_OUT-1:0] live_r, live_n_s;
    logic [CW_OUT-1:0] drop_r, drop_n_s;

    // Fetch queue
    logic [31:0]     q_pc_r    [FQ_DEPTH];
    logic [31:0]     q_inst_r  [FQ_DEPTH];
    logic            q_fault_r [FQ_DEPTH];
    logic [PW-1:0]   wr_ptr_r, wr_ptr_n_s;
    logic [PW-1:0]   rd_ptr_r, rd_ptr_n_s;
    logic [CW_Q-1:0] count_r, count_n_s;

    logic        ar_hs_s;
    logic        r_hs_s;
    logic        r_drop_s;
    logic        push_s;
    logic        pop_s;
    logic        fault_s;
    logic [31:0] out_sum_s;
    logic [31:0] q_sum_s;

    assign rready_o = rst_ni;

    // Handshake qualifiers for the current cycle
    always_comb begin
        ar_hs_s  = arvalid_r & arready_i;
        r_hs_s   = rvalid_i & rst_ni;
        r_drop_s = r_hs_s & (drop_r != {CW_OUT{1'b0}});
        fault_s  = (rresp_i != 2'b00);
        // A redirect in the same cycle turns both the push and the pop into no-ops.
        push_s   = r_hs_s & ~r_drop_s & ~redirect_valid_i;
        pop_s    = (count_r != {CW_Q{1'b0}}) & inst_ready_i & ~redirect_valid_i;
    end

    // Next-state computation for fetch control, counters and queue pointers
    always_comb begin
        fetch_pc_n_s = fetch_pc_r;
        rsp_pc_n_s   = rsp_pc_r;
        halted_n_s   = halted_r;
        live_n_s     = live_r;
        drop_n_s     = drop_r;
        count_n_s    = count_r;
        wr_ptr_n_s   = wr_ptr_r;
        rd_ptr_n_s   = rd_ptr_r;
        arvalid_n_s  = arvalid_r;
        araddr_n_s   = araddr_r;
        ar_stale_n_s = ar_stale_r;
        out_sum_s    = 32'd0;
        q_sum_s      = 32'd0;

        if (redirect_valid_i) begin
            fetch_pc_n_s = redirect_pc_i;
            rsp_pc_n_s   = redirect_pc_i;
            halted_n_s   = 1'b0;
            live_n_s     = {CW_OUT{1'b0}};
            // Everything still in flight becomes a drop, including an AR accepted now;
            // an R beat arriving now retires one of them immediately.
            drop_n_s     = drop_r + live_r + CW_OUT'(ar_hs_s) - CW_OUT'(r_hs_s);
            count_n_s    = {CW_Q{1'b0}};
            wr_ptr_n_s   = {PW{1'b0}};
            rd_ptr_n_s   = {PW{1'b0}};
        end else begin
            if (ar_hs_s && !ar_stale_r) begin
                fetch_pc_n_s = fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_n_s = fetch_pc_r;
            end
            if (push_s) begin
                rsp_pc_n_s = rsp_pc_r + 32'd4;
                wr_ptr_n_s = wr_ptr_r + PW'(1'b1);
            end else begin
                rsp_pc_n_s = rsp_pc_r;
                wr_ptr_n_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_n_s = rd_ptr_r + PW'(1'b1);
            end else begin
                rd_ptr_n_s = rd_ptr_r;
            end
            halted_n_s = halted_r | (push_s & fault_s);
            live_n_s   = live_r + CW_OUT'(ar_hs_s & ~ar_stale_r) - CW_OUT'(push_s);
            drop_n_s   = drop_r + CW_OUT'(ar_hs_s & ar_stale_r) - CW_OUT'(r_drop_s);
            count_n_s  = count_r + CW_Q'(push_s) - CW_Q'(pop_s);
        end

        out_sum_s = 32'(live_n_s) + 32'(drop_n_s);
        // Queue space is reserved for every live read so R never has to stall.
        q_sum_s   = 32'(count_n_s) + 32'(live_n_s);

        if (arvalid_r && !arready_i) begin
            // A pending AR is never withdrawn or changed, even across a redirect.
            arvalid_n_s  = 1'b1;
            araddr_n_s   = araddr_r;
            ar_stale_n_s = ar_stale_r | redirect_valid_i;
        end else begin
            ar_stale_n_s = 1'b0;
            araddr_n_s   = fetch_pc_n_s;
            arvalid_n_s  = ~halted_n_s & (out_sum_s < MAX_OUT_C) & (q_sum_s < FQ_DEPTH_C);
        end
    end

    // State registers and fetch-queue storage
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            araddr_r   <= RESET_PC;
            arvalid_r  <= 1'b0;
            ar_stale_r <= 1'b0;
            halted_r   <= 1'b0;
            live_r     <= {CW_OUT{1'b0}};
            drop_r     <= {CW_OUT{1'b0}};
            count_r    <= {CW_Q{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            for (int i = 0; i < FQ_DEPTH; i++) begin
                q_pc_r[i]    <= 32'd0;
                q_inst_r[i]  <= 32'd0;
                q_fault_r[i] <= 1'b0;
            end
        end else begin
            fetch_pc_r <= fetch_pc_n_s;
            rsp_pc_r   <= rsp_pc_n_s;
            araddr_r   <= araddr_n_s;
            arvalid_r  <= arvalid_n_s;
            ar_stale_r <= ar_stale_n_s;
            halted_r   <= halted_n_s;
            live_r     <= live_n_s;
            drop_r     <= drop_n_s;
            count_r    <= count_n_s;
            wr_ptr_r   <= wr_ptr_n_s;
            rd_ptr_r   <= rd_ptr_n_s;
            if (push_s) begin
                q_pc_r[wr_ptr_r]    <= rsp_pc_r;
                q_inst_r[wr_ptr_r]  <= rdata_i;
                q_fault_r[wr_ptr_r] <= fault_s;
            end
        end
    end

    assign arvalid_o    = arvalid_r;
    assign araddr_o     = araddr_r;
    assign inst_valid_o = (count_r != {CW_Q{1'b0}});
    assign inst_pc_o    = q_pc_r[rd_ptr_r];
    assign inst_snpc_o  = q_pc_r[rd_ptr_r] + 32'd4;
    assign inst_o       = q_inst_r[rd_ptr_r];
    assign inst_fault_o = q_fault_r[rd_ptr_r];

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed and table-driven bench for ifu_prefetch.
//   A behavioural AXI-lite slave returns mem_data(addr) one cycle after each
//   accepted AR (optionally with random stalls and a faulting address); a
//   monitor logs accepted ARs and popped queue entries for comparison.
module tb_ifu_prefetch;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_snpc_o;
    logic [31:0] inst_o;
    logic        inst_fault_o;

    ifu_prefetch dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .araddr_o         (araddr_o),
        .arvalid_o        (arvalid_o),
        .arready_i        (arready_i),
        .rdata_i          (rdata_i),
        .rresp_i          (rresp_i),
        .rvalid_i         (rvalid_i),
        .rready_o         (rready_o),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_pc_o        (inst_pc_o),
        .inst_snpc_o      (inst_snpc_o),
        .inst_o           (inst_o),
        .inst_fault_o     (inst_fault_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] snpc;
        logic [31:0] inst;
        logic        fault;
    } pop_t;

    typedef struct packed {
        logic [31:0]       tgt;
        logic [3:0][31:0]  exp_pc;   // written first..fourth, read as exp_pc[3-j]
    } vec_t;

    int          ncmp = 0;
    int          nfail = 0;
    logic [1:0]  ar_mode = 2'd0;     // 0: arready high, 1: low, 2: random
    logic        rhold = 1'b0;
    logic        rstall_en = 1'b0;
    logic        rand_ready = 1'b0;
    logic [31:0] fault_addr = 32'h0000_0001;
    logic [31:0] pend[$];
    logic [31:0] ar_log[$];
    pop_t        pops[$];
    logic        prev_hold;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_pop(input string nm, input int idx, input logic [31:0] pc, input logic f);
        if (idx >= pops.size()) begin
            ncmp++;
            nfail++;
            $display("FAIL %s: entry %0d missing, only %0d popped", nm, idx, pops.size());
        end else begin
            chk({nm, ".pc"}, pops[idx].pc, pc);
            chk({nm, ".snpc"}, pops[idx].snpc, pc + 32'd4);
            chk({nm, ".inst"}, pops[idx].inst, mem_data(pc));
            chk({nm, ".fault"}, {31'd0, pops[idx].fault}, {31'd0, f});
        end
    endtask

    // AXI-lite slave and monitor: drive at posedge+1, observe at negedge+2
    initial begin
        arready_i = 1'b0;
        rvalid_i  = 1'b0;
        rdata_i   = 32'd0;
        rresp_i   = 2'b00;
        prev_hold = 1'b0;
        prev_addr = 32'd0;
        forever begin
            @(posedge clk_i);
            #1;
            case (ar_mode)
                2'd0:    arready_i = 1'b1;
                2'd1:    arready_i = 1'b0;
                default: arready_i = 1'($urandom_range(0, 1));
            endcase
            if (!rhold && pend.size() != 0 && (!rstall_en || $urandom_range(0, 3) != 0)) begin
                rvalid_i = 1'b1;
                rdata_i  = mem_data(pend[0]);
                rresp_i  = (pend[0] == fault_addr) ? 2'b10 : 2'b00;
            end else begin
                rvalid_i = 1'b0;
                rdata_i  = 32'd0;
                rresp_i  = 2'b00;
            end
            @(negedge clk_i);
            #2;
            if (rst_ni && prev_hold) begin
                ncmp++;
                if (!arvalid_o || araddr_o !== prev_addr) begin
                    nfail++;
                    $display("FAIL ar_stable: got valid=%b addr=%h expected valid=1 addr=%h",
                             arvalid_o, araddr_o, prev_addr);
                end
            end
            prev_hold = rst_ni && arvalid_o && !arready_i;
            prev_addr = araddr_o;
            if (rst_ni && arvalid_o && arready_i) begin
                pend.push_back(araddr_o);
                ar_log.push_back(araddr_o);
            end
            if (rvalid_i && rready_o && pend.size() != 0) begin
                void'(pend.pop_front());
            end
            if (rst_ni && inst_valid_o && inst_ready_i && !redirect_valid_i) begin
                pops.push_back('{pc: inst_pc_o, snpc: inst_snpc_o, inst: inst_o, fault: inst_fault_o});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        @(negedge clk_i);
        #3;
    endtask

    task automatic apply_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        redirect_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        #4;
        pend.delete();
        ar_log.delete();
        pops.delete();
        @(posedge clk_i);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] pc, output int base);
        @(posedge clk_i);
        #1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = pc;
        base = pops.size();
        @(posedge clk_i);
        #1;
        redirect_valid_i = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, input string nm);
        int k = 0;
        while (pops.size() < n && k < budget) begin
            @(posedge clk_i);
            #1;
            if (rand_ready) inst_ready_i = 1'($urandom_range(0, 1));
            k++;
        end
        if (pops.size() < n) begin
            ncmp++;
            nfail++;
            $display("FAIL %s: timeout, got %0d entries expected %0d", nm, pops.size(), n);
        end
        tick(0);
    endtask

    task automatic wait_ar(input int n, input int budget, input string nm);
        int k = 0;
        while (ar_log.size() < n && k < budget) begin
            @(posedge clk_i);
            k++;
        end
        if (ar_log.size() < n) begin
            ncmp++;
            nfail++;
            $display("FAIL %s: timeout, got %0d ARs expected %0d", nm, ar_log.size(), n);
        end
        tick(0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached with %0d failures", nfail);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   base;
        logic found;

        tbl[0] = '{tgt: 32'hFFFF_FFF8, exp_pc: {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004}};
        tbl[1] = '{tgt: 32'h0000_1000, exp_pc: {32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C}};
        tbl[2] = '{tgt: 32'h7FFF_FFFC, exp_pc: {32'h7FFF_FFFC, 32'h8000_0000, 32'h8000_0004, 32'h8000_0008}};
        tbl[3] = '{tgt: 32'h2000_0100, exp_pc: {32'h2000_0100, 32'h2000_0104, 32'h2000_0108, 32'h2000_010C}};

        rst_ni = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i = 32'd0;
        inst_ready_i = 1'b0;

        // Reset state
        tick(3);
        chk("rst.arvalid", {31'd0, arvalid_o}, 32'd0);
        chk("rst.araddr", araddr_o, 32'h2000_0000);
        chk("rst.inst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst.rready", {31'd0, rready_o}, 32'd0);

        // Streaming fetch, one AR per cycle
        inst_ready_i = 1'b1;
        release_reset();
        tick(10);
        chk("t1.ar_count", ar_log.size(), 32'd10);
        chk("t1.rready", {31'd0, rready_o}, 32'd1);
        wait_pops(8, 100, "t1.wait");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1.araddr%0d", i), ar_log[i], 32'h2000_0000 + 32'(4 * i));
            chk_pop($sformatf("t1.pop%0d", i), i, 32'h2000_0000 + 32'(4 * i), 1'b0);
        end

        // Queue full: exactly FQ_DEPTH reads, then one more after a single pop
        apply_reset();
        inst_ready_i = 1'b0;
        release_reset();
        tick(30);
        chk("t2.ar_count", ar_log.size(), 32'd4);
        chk("t2.arvalid", {31'd0, arvalid_o}, 32'd0);
        chk("t2.head_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("t2.head_pc", inst_pc_o, 32'h2000_0000);
        @(posedge clk_i);
        #1;
        inst_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        inst_ready_i = 1'b0;
        tick(10);
        chk("t2.ar_count2", ar_log.size(), 32'd5);
        chk("t2.ar5", ar_log[4], 32'h2000_0010);
        chk("t2.pops", pops.size(), 32'd1);

        // Redirect with two reads outstanding: both responses dropped
        apply_reset();
        inst_ready_i = 1'b1;
        rhold = 1'b1;
        release_reset();
        wait_ar(2, 50, "t3.wait_ar");
        tick(3);
        chk("t3.ar_count", ar_log.size(), 32'd2);
        redirect(32'h8000_0000, base);
        tick(2);
        rhold = 1'b0;
        wait_pops(2, 100, "t3.wait");
        chk("t3.ar3", ar_log[2], 32'h8000_0000);
        chk_pop("t3.pop0", 0, 32'h8000_0000, 1'b0);
        chk_pop("t3.pop1", 1, 32'h8000_0004, 1'b0);

        // Redirect while an AR is stalled: old address held, its response dropped
        apply_reset();
        ar_mode = 2'd1;
        inst_ready_i = 1'b1;
        release_reset();
        tick(4);
        chk("t4.arvalid", {31'd0, arvalid_o}, 32'd1);
        chk("t4.araddr", araddr_o, 32'h2000_0000);
        redirect(32'h8000_0000, base);
        tick(2);
        chk("t4.hold_valid", {31'd0, arvalid_o}, 32'd1);
        chk("t4.hold_addr", araddr_o, 32'h2000_0000);
        ar_mode = 2'd0;
        wait_pops(1, 100, "t4.wait");
        chk("t4.ar0", ar_log[0], 32'h2000_0000);
        chk("t4.ar1", ar_log[1], 32'h8000_0000);
        chk_pop("t4.pop0", 0, 32'h8000_0000, 1'b0);

        // Access fault halts fetch until a redirect
        fault_addr = 32'h2000_0008;
        apply_reset();
        inst_ready_i = 1'b1;
        release_reset();
        tick(40);
        chk("t5.ar_count", ar_log.size(), 32'd4);
        chk("t5.arvalid", {31'd0, arvalid_o}, 32'd0);
        chk_pop("t5.pop1", 1, 32'h2000_0004, 1'b0);
        chk_pop("t5.pop2", 2, 32'h2000_0008, 1'b1);
        chk_pop("t5.pop3", 3, 32'h2000_000C, 1'b0);
        fault_addr = 32'h0000_0001;
        redirect(32'h8000_0000, base);
        wait_pops(base + 2, 100, "t5.wait");
        chk_pop("t5.res0", base, 32'h8000_0000, 1'b0);
        chk_pop("t5.res1", base + 1, 32'h8000_0004, 1'b0);

        // Redirect coinciding with an R beat, an AR handshake and a pop
        apply_reset();
        inst_ready_i = 1'b1;
        release_reset();
        tick(6);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk_i);
            #1;
            if (rvalid_i && inst_valid_o && arvalid_o && arready_i) found = 1'b1;
        end
        if (!found) begin
            ncmp++;
            nfail++;
            $display("FAIL t6.setup: got no cycle with R+pop+AR, expected one within 20 cycles");
        end else begin
            redirect_valid_i = 1'b1;
            redirect_pc_i = 32'h4000_0000;
            base = pops.size();
            @(posedge clk_i);
            #1;
            redirect_valid_i = 1'b0;
            tick(0);
            chk("t6.empty1", {31'd0, inst_valid_o}, 32'd0);
            tick(1);
            chk("t6.empty2", {31'd0, inst_valid_o}, 32'd0);
            wait_pops(base + 3, 100, "t6.wait");
            chk_pop("t6.pop0", base, 32'h4000_0000, 1'b0);
            chk_pop("t6.pop1", base + 1, 32'h4000_0004, 1'b0);
            chk_pop("t6.pop2", base + 2, 32'h4000_0008, 1'b0);
        end

        // Table of redirect targets under random AR/R/decode stalls
        ar_mode = 2'd2;
        rstall_en = 1'b1;
        rand_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            redirect(tbl[v].tgt, base);
            wait_pops(base + 4, 400, $sformatf("tbl%0d.wait", v));
            for (int j = 0; j < 4; j++) begin
                chk_pop($sformatf("tbl%0d.pop%0d", v, j), base + j, tbl[v].exp_pc[3-j], 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
        $finish;
    end

endmodule
